// File: rtl/ov5640_init_sequencer_pkg.sv
// Shared types and constants for the OV5640 init sequencer.
// Holds the FSM state enum, ROM entry field slices and 50 MHz wait defaults.
package ov5640_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int REG_ADDR_MSB = 23;
  localparam int REG_ADDR_LSB = 8;
  localparam int DATA_MSB     = 7;

  localparam int POWERUP_CYCLES_50M     = 1_000_000;
  localparam int RESET_DELAY_CYCLES_50M = 250_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov5640_init_sequencer_if.sv
// SCCB write request/completion bundle between sequencer and SCCB master.
// go/reg_addr/wdata flow master->slave; done/ack_err flow back.
interface ov5640_init_sequencer_if;

  logic        go;
  logic [15:0] reg_addr;
  logic [7:0]  wdata;
  logic        done;
  logic        ack_err;

  modport master (
    output go,
    output reg_addr,
    output wdata,
    input  done,
    input  ack_err
  );

  modport slave (
    input  go,
    input  reg_addr,
    input  wdata,
    output done,
    output ack_err
  );

endinterface

// File: rtl/ov5640_init_sequencer_delay_timer.sv
// Loadable down-counter shared by the power-up and post-reset waits.
// Ports: clk, reset, load, load_value -> expired (count is zero).
module ov5640_delay_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init ROM and issues one SCCB write per entry.
// Ports: clk, reset, start, rom_addr/rom_q, sccb (master), busy,
// init_done, init_err, reg_index.
module ov5640_init_sequencer
  import ov5640_pkg::*;
#(
  parameter int ADDR_WIDTH         = 8,
  parameter int INIT_REG_NUM       = 252,
  parameter int RESET_IDX          = 1,
  parameter int POWERUP_CYCLES     = POWERUP_CYCLES_50M,
  parameter int RESET_DELAY_CYCLES = RESET_DELAY_CYCLES_50M,
  parameter int MAX_RETRY          = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  ov5640_init_sequencer_if.master sccb,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] reg_index
);

  localparam int DLY_MAX =
    max_int(POWERUP_CYCLES, RESET_DELAY_CYCLES);
  localparam int DLY_W =
    (DLY_MAX < 1) ? 1 : $clog2(DLY_MAX + 1);
  localparam int RTY_W =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(INIT_REG_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] RST_IDX =
    ADDR_WIDTH'(RESET_IDX);
  localparam logic [RTY_W-1:0] RTY_MAX =
    RTY_W'(MAX_RETRY);

  // Timer counts down to zero inclusive, so load N-1 for an N-cycle
  // wait; zero still costs the single cycle spent in the wait state.
  localparam logic [DLY_W-1:0] PWR_LOAD =
    DLY_W'((POWERUP_CYCLES == 0) ? 0 : POWERUP_CYCLES - 1);
  localparam logic [DLY_W-1:0] RST_LOAD =
    DLY_W'((RESET_DELAY_CYCLES == 0) ? 0 : RESET_DELAY_CYCLES - 1);

  if (INIT_REG_NUM > 2**ADDR_WIDTH || INIT_REG_NUM < 1) begin : g_cfg_chk
    $error("INIT_REG_NUM does not fit ADDR_WIDTH");
  end

  state_e                r_state;
  state_e                w_next;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [RTY_W-1:0]      r_retry;
  logic [15:0]           r_reg_addr;
  logic [7:0]            r_wdata;

  logic                  w_load;
  logic [DLY_W-1:0]      w_load_val;
  logic                  w_expired;
  logic                  w_clr;
  logic                  w_idx_inc;
  logic                  w_rty_inc;
  logic                  w_rty_clr;
  logic                  w_capture;

  ov5640_delay_timer #(
    .WIDTH (DLY_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_value (w_load_val),
    .expired    (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_retry    <= '0;
      r_reg_addr <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_index <= '0;
      end else if (w_idx_inc) begin
        r_index <= r_index + 1'b1;
      end
      if (w_clr || w_rty_clr) begin
        r_retry <= '0;
      end else if (w_rty_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_capture) begin
        r_reg_addr <= rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
        r_wdata    <= rom_q[DATA_MSB:0];
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_clr      = 1'b0;
    w_idx_inc  = 1'b0;
    w_rty_inc  = 1'b0;
    w_rty_clr  = 1'b0;
    w_capture  = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_clr      = 1'b1;
          w_load     = 1'b1;
          w_load_val = PWR_LOAD;
          w_next     = ST_PWR_WAIT;
        end
      end
      ST_PWR_WAIT: begin
        if (w_expired) w_next = ST_FETCH;
      end
      ST_FETCH: w_next = ST_LATCH;
      ST_LATCH: begin
        w_capture = 1'b1;
        w_next    = ST_ISSUE;
      end
      ST_ISSUE: w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sccb.done) begin
          if (!sccb.ack_err) begin
            w_rty_clr = 1'b1;
            if (r_index == RST_IDX) begin
              w_load     = 1'b1;
              w_load_val = RST_LOAD;
              w_next     = ST_DELAY;
            end else begin
              w_next = ST_NEXT;
            end
          end else if (r_retry < RTY_MAX) begin
            // Retry reuses the captured payload; no ROM re-read.
            w_rty_inc = 1'b1;
            w_next    = ST_ISSUE;
          end else begin
            w_next = ST_ERROR;
          end
        end
      end
      ST_DELAY: begin
        if (w_expired) w_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_index == LAST_IDX) begin
          w_next = ST_DONE;
        end else begin
          w_idx_inc = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registers so reset clears them at once.
  assign sccb.go       = (r_state == ST_ISSUE);
  assign sccb.reg_addr = r_reg_addr;
  assign sccb.wdata    = r_wdata;
  assign rom_addr      = r_index;
  assign reg_index     = r_index;
  assign init_done     = (r_state == ST_DONE);
  assign init_err      = (r_state == ST_ERROR);
  assign busy          = !((r_state == ST_IDLE) ||
                           (r_state == ST_DONE) ||
                           (r_state == ST_ERROR));

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Directed bench for ov5640_init_sequencer: 4-entry ROM, SCCB responder
// with 5-clk latency and programmable NAKs on register 0x3103.
module tb_ov5640_init_sequencer;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_q;
  logic        busy;
  logic        init_done;
  logic        init_err;
  logic [7:0]  reg_index;

  ov5640_init_sequencer_if sif ();

  ov5640_init_sequencer #(
    .ADDR_WIDTH         (8),
    .INIT_REG_NUM       (4),
    .RESET_IDX          (1),
    .POWERUP_CYCLES     (10),
    .RESET_DELAY_CYCLES (20),
    .MAX_RETRY          (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .sccb      (sif),
    .busy      (busy),
    .init_done (init_done),
    .init_err  (init_err),
    .reg_index (reg_index)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [4];
  logic [23:0] exp_rom [4];

  always @(posedge clk)
    rom_q <= (rom_addr < 8'd4) ? rom[rom_addr[1:0]] : 24'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_clr = 1'b0;
  int          nak_plan = 0;
  logic        m_done, m_ack, m_pend, start_seen;
  logic [15:0] m_addr;
  int          m_lat, go_cnt, done_cnt, nak_given, start_cyc;
  int          go_cyc [16];
  int          done_cyc [16];
  logic [23:0] go_log [16];

  assign sif.done    = m_done;
  assign sif.ack_err = m_ack;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_done <= 1'b0; m_ack <= 1'b0; m_pend <= 1'b0;
      m_lat <= 0; go_cnt <= 0; done_cnt <= 0;
      nak_given <= 0; start_seen <= 1'b0; start_cyc <= 0;
      m_addr <= '0;
    end else if (m_clr) begin
      go_cnt <= 0; done_cnt <= 0; nak_given <= 0;
      start_seen <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_ack  <= 1'b0;
      if (start && !start_seen) begin
        start_cyc  <= cyc;
        start_seen <= 1'b1;
      end
      if (m_done && done_cnt < 16) begin
        done_cyc[done_cnt[3:0]] <= cyc;
        done_cnt <= done_cnt + 1;
      end
      if (sif.go) begin
        if (go_cnt < 16) begin
          go_cyc[go_cnt[3:0]] <= cyc;
          go_log[go_cnt[3:0]] <= {sif.reg_addr, sif.wdata};
        end
        go_cnt <= go_cnt + 1;
        m_pend <= 1'b1;
        m_lat  <= LAT - 2;
        m_addr <= sif.reg_addr;
      end else if (m_pend) begin
        if (m_lat == 0) begin
          m_pend <= 1'b0;
          m_done <= 1'b1;
          if (m_addr == 16'h3103 && nak_given < nak_plan) begin
            m_ack     <= 1'b1;
            nak_given <= nak_given + 1;
          end
        end else begin
          m_lat <= m_lat - 1;
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic clr_model(input int naks);
    nak_plan = naks;
    @(negedge clk) m_clr = 1'b1;
    @(negedge clk) m_clr = 1'b0;
  endtask

  task automatic wait_go(input string tag, input int n);
    int k = 0;
    while (go_cnt < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(go_cnt >= n), 32'd1);
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(init_done || init_err) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(init_done || init_err), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_entries(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_e%0d", tag, i), 32'(go_log[i]),
          32'(exp_rom[i]));
  endtask

  initial begin
    exp_rom[0] = 24'h310811;
    exp_rom[1] = 24'h300882;
    exp_rom[2] = 24'h310303;
    exp_rom[3] = 24'h300842;
    for (int i = 0; i < 4; i++) rom[i] = exp_rom[i];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outs",
        32'({busy, init_done, init_err, sif.go}), 32'd0);
    chk("rst_idx", 32'({rom_addr, reg_index}), 32'd0);
    chk("rst_payload", 32'({sif.reg_addr, sif.wdata}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // normal run with an ignored start while busy
    clr_model(0);
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_go("t1_wait2", 2);
    pulse_start();
    wait_end("t1_end");
    chk("t1_gocnt", 32'(go_cnt), 32'd4);
    chk_entries("t1");
    chk("t1_first", 32'(go_cyc[0] - start_cyc), 32'd13);
    chk("t1_gap0", 32'(go_cyc[1] - done_cyc[0]), 32'd4);
    chk("t1_gap1", 32'(go_cyc[2] - done_cyc[1]), 32'd24);
    chk("t1_gap2", 32'(go_cyc[3] - done_cyc[2]), 32'd4);
    chk("t1_flags", 32'({init_done, init_err, busy}), 32'b100);

    // restart after DONE
    clr_model(0);
    pulse_start();
    chk("t2_clr", 32'({init_done, busy}), 32'b01);
    wait_end("t2_end");
    chk("t2_gocnt", 32'(go_cnt), 32'd4);
    chk_entries("t2");
    chk("t2_flags", 32'({init_done, init_err, busy}), 32'b100);

    // two NAKs then ack; ROM entry 2 poisoned after its first go
    clr_model(2);
    pulse_start();
    wait_go("t3_wait3", 3);
    rom[2] = 24'hABCDEF;
    wait_end("t3_end");
    rom[2] = exp_rom[2];
    chk("t3_gocnt", 32'(go_cnt), 32'd6);
    chk("t3_try0", 32'(go_log[2]), 32'h310303);
    chk("t3_try1", 32'(go_log[3]), 32'h310303);
    chk("t3_try2", 32'(go_log[4]), 32'h310303);
    chk("t3_e3", 32'(go_log[5]), 32'(exp_rom[3]));
    chk("t3_flags", 32'({init_done, init_err, busy}), 32'b100);

    // four NAKs: abort
    clr_model(4);
    pulse_start();
    wait_end("t4_end");
    chk("t4_flags", 32'({init_done, init_err, busy}), 32'b010);
    chk("t4_idx", 32'(reg_index), 32'd2);
    chk("t4_gocnt", 32'(go_cnt), 32'd6);
    repeat (30) @(negedge clk);
    chk("t4_sticky", 32'({go_cnt, 1'b0, init_err}), {30'd6, 2'b01});

    // reset in WAIT_DONE of entry 3
    clr_model(0);
    pulse_start();
    wait_go("t5_wait4", 4);
    chk("t5_pre", 32'({busy, reg_index}), {23'd0, 1'b1, 8'd3});
    #2 reset = 1'b1;
    #1;
    chk("t5_outs",
        32'({busy, init_done, init_err, sif.go}), 32'd0);
    chk("t5_idx", 32'({rom_addr, reg_index}), 32'd0);
    chk("t5_payload", 32'({sif.reg_addr, sif.wdata}), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_end("t5_end");
    chk("t5_gocnt", 32'(go_cnt), 32'd4);
    chk("t5_first", 32'(go_cyc[0] - start_cyc), 32'd13);
    chk_entries("t5");
    chk("t5_flags", 32'({init_done, init_err, busy}), 32'b100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
